// File: rtl/vk_port_arbiter.sv
// Registered arbiter for the shared video/keyboard memory port: VGA fetches win
// outright, while buffered key writes and CPU accesses alternate round-robin.
module vk_port_arbiter #(
   parameter logic [31:0] KEY_BASE   = 32'h0000_20D0,
   parameter int          KEY_SLOTS  = 16,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                         sys_clk,
   input  logic                         rst,
   input  logic                         vga_req,
   input  logic [31:0]                  vga_addr,
   output logic                         vga_rvalid,
   output logic [31:0]                  vga_rdata,
   input  logic                         key_valid,
   input  logic [31:0]                  key_data,
   output logic [$clog2(KEY_SLOTS)-1:0] key_wptr,
   output logic                         key_overflow,
   input  logic                         cpu_req,
   input  logic                         cpu_we,
   input  logic [31:0]                  cpu_addr,
   input  logic [31:0]                  cpu_wdata,
   output logic                         cpu_ack,
   output logic [31:0]                  cpu_rdata,
   output logic [31:0]                  mem_addr,
   output logic                         mem_wren,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata
);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(KEY_SLOTS);

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_VGA  = 2'd1;
   localparam logic [1:0] TAG_CPU  = 2'd2;

   logic [31:0] fifo_mem [FIFO_DEPTH];
   logic [FW:0] fifo_rd;
   logic [FW:0] fifo_wr;
   logic        fifo_empty;
   logic        fifo_full;

   logic        rr_key;
   logic        cpu_busy;
   logic        wr_ack;
   logic [1:0]  tag1;
   logic [1:0]  tag2;

   logic        key_elig;
   logic        cpu_elig;
   logic        grant_vga;
   logic        grant_key;
   logic        grant_cpu;
   logic        key_code;
   logic        push;
   logic        drop;

   // Extra wrap bit on the pointers tells full from empty.
   assign fifo_empty = (fifo_rd == fifo_wr);
   assign fifo_full  = (fifo_rd[FW] != fifo_wr[FW]) &&
                       (fifo_rd[FW-1:0] == fifo_wr[FW-1:0]);

   assign key_elig = !fifo_empty;
   assign cpu_elig = cpu_req && !cpu_busy;

   always_comb begin
      grant_vga = vga_req;
      grant_key = 1'b0;
      grant_cpu = 1'b0;
      if (!vga_req) begin
         if (key_elig && cpu_elig) begin
            grant_key = rr_key;
            grant_cpu = !rr_key;
         end else begin
            grant_key = key_elig;
            grant_cpu = cpu_elig;
         end
      end
   end

   // A pop in the same cycle frees the slot a push would otherwise need.
   assign key_code = key_valid && (key_data != '0);
   assign push     = key_code && (!fifo_full || grant_key);
   assign drop     = key_code && fifo_full && !grant_key;

   // NOTE: FIFO storage has no reset; the pointers alone define its contents.
   always_ff @(posedge sys_clk) begin
      if (push) fifo_mem[fifo_wr[FW-1:0]] <= key_data;
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         fifo_rd      <= '0;
         fifo_wr      <= '0;
         rr_key       <= 1'b1;
         cpu_busy     <= 1'b0;
         wr_ack       <= 1'b0;
         tag1         <= TAG_NONE;
         tag2         <= TAG_NONE;
         key_wptr     <= '0;
         key_overflow <= 1'b0;
         mem_addr     <= '0;
         mem_wren     <= 1'b0;
         mem_wdata    <= '0;
      end else begin
         mem_wren <= grant_key || (grant_cpu && cpu_we);
         if (grant_vga) begin
            mem_addr <= vga_addr;
         end else if (grant_key) begin
            mem_addr  <= KEY_BASE + 32'(key_wptr);
            mem_wdata <= fifo_mem[fifo_rd[FW-1:0]];
            key_wptr  <= key_wptr + PW'(1);
         end else if (grant_cpu) begin
            mem_addr <= cpu_addr;
            if (cpu_we) mem_wdata <= cpu_wdata;
         end

         if (grant_key)      rr_key <= 1'b0;
         else if (grant_cpu) rr_key <= 1'b1;

         if (push) fifo_wr <= fifo_wr + 1'b1;
         if (grant_key) fifo_rd <= fifo_rd + 1'b1;
         if (drop) key_overflow <= 1'b1;

         // Owner tag follows each read through issue and RAM latency.
         tag1   <= grant_vga ? TAG_VGA : ((grant_cpu && !cpu_we) ? TAG_CPU : TAG_NONE);
         tag2   <= tag1;
         wr_ack <= grant_cpu && cpu_we;

         if (grant_cpu)    cpu_busy <= 1'b1;
         else if (cpu_ack) cpu_busy <= 1'b0;
      end
   end

   assign vga_rvalid = (tag2 == TAG_VGA);
   assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
   assign cpu_ack    = wr_ack || (tag2 == TAG_CPU);
   assign cpu_rdata  = (tag2 == TAG_CPU) ? mem_rdata : '0;

endmodule

// File: tb/tb_vk_port_arbiter.sv
// Self-checking bench for vk_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_vk_port_arbiter;
   localparam logic [31:0] KEY_BASE   = 32'h0000_20D0;
   localparam int          KEY_SLOTS  = 16;
   localparam int          FIFO_DEPTH = 4;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b0;
   logic        vga_req = 1'b0;
   logic [31:0] vga_addr = '0;
   logic        vga_rvalid;
   logic [31:0] vga_rdata;
   logic        key_valid = 1'b0;
   logic [31:0] key_data = '0;
   logic [3:0]  key_wptr;
   logic        key_overflow;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic [31:0] mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   vk_port_arbiter #(
      .KEY_BASE(KEY_BASE), .KEY_SLOTS(KEY_SLOTS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .sys_clk(sys_clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .key_valid(key_valid), .key_data(key_data), .key_wptr(key_wptr), .key_overflow(key_overflow),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous RAM: data for the address presented in one cycle appears in the next.
   logic [31:0] ram [0:16383] = '{default: '0};
   always @(posedge sys_clk) begin
      if (!rst) begin
         ram[14'h100] <= 32'h41;
         ram[14'h101] <= 32'h55;
      end else if (mem_wren) begin
         ram[mem_addr[13:0]] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr[13:0]];
   end

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          ack_cnt = 0;
   always @(negedge sys_clk) begin
      if (rst && mem_wren) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (cpu_ack) ack_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      vga_req = 1'b0; key_valid = 1'b0; key_data = '0; cpu_req = 1'b0;
      #12;
      @(negedge sys_clk);
      rst = 1'b1;
   endtask

   task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      lat = -1;
      rdata = '0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (cpu_ack) begin
            lat = i;
            rdata = cpu_rdata;
            break;
         end
      end
      tick();
      cpu_req = 1'b0;
   endtask

   typedef struct {
      logic        vga_req;
      logic [31:0] vga_addr;
      logic        key_valid;
      logic [31:0] key_data;
      logic [31:0] e_addr;
      logic        e_wren;
      logic [31:0] e_wdata;
      logic        e_rvalid;
      logic [31:0] e_rdata;
      logic [3:0]  e_wptr;
   } vec_t;

   // Reference model state for the randomized run.
   typedef struct {
      int          due;
      bit          is_cpu;
      logic [31:0] data;
   } ret_t;

   ret_t        ret_q[$];
   logic [31:0] m_keys[$];
   logic [31:0] ref_mem [16];
   logic [31:0] e_addr;
   logic [31:0] e_wdata;
   logic        e_wren;
   int          m_wptr;
   int          m_busy;
   bit          m_next_key;
   bit          m_ovf;
   int          cyc;

   task automatic model_eval();
      bit key_ok;
      bit cpu_ok;
      int g;
      key_ok = m_keys.size() > 0;
      cpu_ok = cpu_req && (m_busy == 0);
      if (vga_req)              g = 1;
      else if (key_ok && cpu_ok) g = m_next_key ? 2 : 3;
      else if (key_ok)          g = 2;
      else if (cpu_ok)          g = 3;
      else                      g = 0;
      if (m_busy > 0) m_busy--;
      e_wren = 1'b0;
      case (g)
         1: begin
            e_addr = vga_addr;
            ret_q.push_back('{cyc + 2, 1'b0, ref_mem[vga_addr[3:0]]});
         end
         2: begin
            e_addr  = KEY_BASE + 32'(m_wptr);
            e_wren  = 1'b1;
            e_wdata = m_keys.pop_front();
            m_wptr  = (m_wptr + 1) % KEY_SLOTS;
            m_next_key = 1'b0;
         end
         3: begin
            e_addr = cpu_addr;
            m_next_key = 1'b1;
            m_busy = cpu_we ? 1 : 2;
            if (cpu_we) begin
               e_wren  = 1'b1;
               e_wdata = cpu_wdata;
               ref_mem[cpu_addr[3:0]] = cpu_wdata;
               ret_q.push_back('{cyc + 1, 1'b1, 32'h0});
            end else begin
               ret_q.push_back('{cyc + 2, 1'b1, ref_mem[cpu_addr[3:0]]});
            end
         end
         default: ;
      endcase
      if (key_valid && key_data != 0) begin
         if (m_keys.size() < FIFO_DEPTH) m_keys.push_back(key_data);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic model_compare();
      logic        e_vv;
      logic        e_ca;
      logic [31:0] e_vd;
      logic [31:0] e_cd;
      e_vv = 0; e_ca = 0; e_vd = '0; e_cd = '0;
      foreach (ret_q[i]) begin
         if (ret_q[i].due == cyc) begin
            if (ret_q[i].is_cpu) begin e_ca = 1; e_cd = ret_q[i].data; end
            else begin e_vv = 1; e_vd = ret_q[i].data; end
         end
      end
      while (ret_q.size() > 0 && ret_q[0].due <= cyc) void'(ret_q.pop_front());
      check("rnd_mem_wren", mem_wren, e_wren);
      check("rnd_mem_addr", mem_addr, e_addr);
      check("rnd_mem_wdata", mem_wdata, e_wdata);
      check("rnd_key_wptr", key_wptr, m_wptr[3:0]);
      check("rnd_key_overflow", key_overflow, m_ovf);
      check("rnd_vga_rvalid", vga_rvalid, e_vv);
      check("rnd_vga_rdata", vga_rdata, e_vd);
      check("rnd_cpu_ack", cpu_ack, e_ca);
      check("rnd_cpu_rdata", cpu_rdata, e_cd);
   endtask

   initial begin
      vec_t        vecs [9];
      int          base;
      int          ack_base;
      int          lat;
      logic [31:0] rd;
      int          vga_left;
      bit          drop_pending;

      // Reset state, then a quiet interval.
      #12;
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wren", mem_wren, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_vga_rvalid", vga_rvalid, 0);
      check("rst_vga_rdata", vga_rdata, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_key_wptr", key_wptr, 0);
      check("rst_key_overflow", key_overflow, 0);
      @(negedge sys_clk);
      rst = 1'b1;
      base = wr_addr_q.size();
      repeat (20) tick();
      check("idle_write_count", wr_addr_q.size() - base, 0);
      check("idle_mem_addr", mem_addr, 0);

      // Cycle-by-cycle vectors: outputs expected in the cycle after the inputs.
      vecs[0] = '{1, 32'h100, 0, 32'h00, 32'h100,  0, 32'h00, 0, 32'h00, 0};
      vecs[1] = '{0, 32'h000, 1, 32'h61, 32'h100,  0, 32'h00, 1, 32'h41, 0};
      vecs[2] = '{0, 32'h000, 0, 32'h00, 32'h20D0, 1, 32'h61, 0, 32'h00, 1};
      vecs[3] = '{0, 32'h000, 1, 32'h00, 32'h20D0, 0, 32'h61, 0, 32'h00, 1};
      vecs[4] = '{1, 32'h101, 1, 32'h62, 32'h101,  0, 32'h61, 0, 32'h00, 1};
      vecs[5] = '{0, 32'h000, 0, 32'h00, 32'h20D1, 1, 32'h62, 1, 32'h55, 2};
      vecs[6] = '{0, 32'h000, 0, 32'h63, 32'h20D1, 0, 32'h62, 0, 32'h00, 2};
      vecs[7] = '{1, 32'h102, 1, 32'h63, 32'h102,  0, 32'h62, 0, 32'h00, 2};
      vecs[8] = '{0, 32'h000, 0, 32'h00, 32'h20D2, 1, 32'h63, 1, 32'h00, 3};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         vga_req = vecs[i].vga_req; vga_addr = vecs[i].vga_addr;
         key_valid = vecs[i].key_valid; key_data = vecs[i].key_data;
         tick();
         check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_mem_wren", i), mem_wren, vecs[i].e_wren);
         check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         check($sformatf("vec%0d_vga_rvalid", i), vga_rvalid, vecs[i].e_rvalid);
         check($sformatf("vec%0d_vga_rdata", i), vga_rdata, vecs[i].e_rdata);
         check($sformatf("vec%0d_key_wptr", i), key_wptr, vecs[i].e_wptr);
      end
      vga_req = 0; key_valid = 0;

      // Seventeen keys: the last one wraps back to slot 0.
      do_reset();
      base = wr_addr_q.size();
      for (int k = 0; k < 17; k++) begin
         key_valid = 1; key_data = 32'h41 + k;
         tick();
      end
      key_valid = 0;
      repeat (5) tick();
      check("wrap_write_count", wr_addr_q.size() - base, 17);
      for (int k = 0; k < 17 && base + k < wr_addr_q.size(); k++) begin
         check($sformatf("wrap_addr%0d", k), wr_addr_q[base + k], KEY_BASE + 32'(k % KEY_SLOTS));
         check($sformatf("wrap_data%0d", k), wr_data_q[base + k], 32'h41 + k);
      end
      check("wrap_key_wptr", key_wptr, 1);
      check("wrap_overflow", key_overflow, 0);

      // VGA hogs the port while six keys arrive: four kept, two dropped.
      do_reset();
      base = wr_addr_q.size();
      vga_req = 1; vga_addr = 32'h100;
      for (int k = 0; k < 6; k++) begin
         key_valid = 1; key_data = 32'h70 + k;
         tick();
      end
      key_valid = 0;
      tick();
      check("ovf_sticky", key_overflow, 1);
      check("ovf_no_write_under_vga", wr_addr_q.size() - base, 0);
      vga_req = 0;
      repeat (8) tick();
      check("ovf_write_count", wr_addr_q.size() - base, 4);
      for (int k = 0; k < 4 && base + k < wr_addr_q.size(); k++) begin
         check($sformatf("ovf_addr%0d", k), wr_addr_q[base + k], KEY_BASE + 32'(k));
         check($sformatf("ovf_data%0d", k), wr_data_q[base + k], 32'h70 + k);
      end
      check("ovf_key_wptr", key_wptr, 4);
      check("ovf_still_sticky", key_overflow, 1);

      // Key and CPU write contend with the pointer on key, then CPU readback.
      do_reset();
      base = wr_addr_q.size();
      ack_base = ack_cnt;
      key_valid = 1; key_data = 32'h6B;
      tick();
      key_valid = 0;
      cpu_txn(1'b1, 32'h30, 32'hDEAD, lat, rd);
      check("contend_write_latency", lat, 2);
      repeat (3) tick();
      check("contend_write_count", wr_addr_q.size() - base, 2);
      if (wr_addr_q.size() - base >= 2) begin
         check("contend_first_addr", wr_addr_q[base], KEY_BASE);
         check("contend_first_data", wr_data_q[base], 32'h6B);
         check("contend_second_addr", wr_addr_q[base + 1], 32'h30);
         check("contend_second_data", wr_data_q[base + 1], 32'hDEAD);
      end
      check("contend_ack_pulses", ack_cnt - ack_base, 1);
      cpu_txn(1'b0, 32'h30, 32'h0, lat, rd);
      check("readback_latency", lat, 2);
      check("readback_data", rd, 32'hDEAD);
      repeat (2) tick();
      check("readback_ack_pulses", ack_cnt - ack_base, 2);

      // Randomized traffic against the model.
      do_reset();
      ret_q.delete(); m_keys.delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      e_addr = '0; e_wdata = '0; e_wren = 0;
      m_wptr = 0; m_busy = 0; m_next_key = 1; m_ovf = 0; cyc = 0;
      vga_left = 0; drop_pending = 0;
      for (int n = 0; n < 3000; n++) begin
         if (vga_left > 0) vga_left--;
         else if ($urandom_range(0, 9) == 0) vga_left = $urandom_range(1, 10);
         vga_req  = (vga_left > 0);
         vga_addr = 32'h200 + $urandom_range(0, 15);
         key_valid = ($urandom_range(0, 2) == 0);
         key_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom_range(1, 255);
         if (cpu_req) begin
            if (drop_pending) begin
               cpu_req = 0;
               drop_pending = 0;
            end else if (cpu_ack) begin
               drop_pending = 1;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            cpu_req   = 1;
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = 32'h200 + $urandom_range(0, 15);
            cpu_wdata = $urandom;
         end
         model_eval();
         tick();
         cyc++;
         model_compare();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
